// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - byte-stream instruction memory loader with word-count header and checksum
module imem_program_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_a,
  output logic [31:0] imem_wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] loaded_words
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] shift_reg;
  logic [31:0] word_total;
  logic [31:0] word_idx;
  logic [7:0]  sum;
  logic [31:0] next_word;
  logic        xfer;

  // Little-endian assembly: the newest byte lands in the top lane, so after
  // four shifts the first byte received sits in bits [7:0].
  assign next_word = {in_data, shift_reg};
  assign in_ready  = !reset && (state == S_HDR || state == S_LOAD || state == S_CSUM);
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_HDR;
      byte_cnt     <= 2'd0;
      shift_reg    <= 24'd0;
      word_total   <= 32'd0;
      word_idx     <= 32'd0;
      sum          <= 8'd0;
      imem_we      <= 1'b0;
      imem_a       <= ADDR_BASE;
      imem_wd      <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      loaded_words <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR: begin
          if (xfer) begin
            shift_reg <= next_word[31:8];
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              word_total <= next_word;
              if (next_word > 32'(MAX_WORDS)) begin
                state <= S_ERR;
                error <= 1'b1;
              end else if (next_word == 32'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_LOAD;
              end
            end
          end
        end

        S_LOAD: begin
          if (xfer) begin
            shift_reg <= next_word[31:8];
            byte_cnt  <= byte_cnt + 2'd1;
            sum       <= sum + in_data;
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_a       <= ADDR_BASE + (word_idx << 2);
              imem_wd      <= next_word;
              loaded_words <= loaded_words + 32'd1;
              word_idx     <= word_idx + 32'd1;
              if (word_idx + 32'd1 == word_total) begin
                state <= S_CSUM;
              end
            end
          end
        end

        S_CSUM: begin
          if (xfer) begin
            if (in_data == sum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        S_DONE: begin
        end

        S_ERR: begin
        end

        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - directed self-checking bench for imem_program_loader
module tb_imem_program_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_a;
  logic [31:0] imem_wd;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [31:0] loaded_words;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];

  imem_program_loader #(.ADDR_BASE(32'h0), .MAX_WORDS(512)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_a(imem_a),
    .imem_wd(imem_wd),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .loaded_words(loaded_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with imem_we high is logged; a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_a.push_back(imem_a);
      wr_d.push_back(imem_wd);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    tests_run++;
    if (t >= 50) begin
      tests_failed++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic send_image(input logic [7:0] csum, input int bubbles);
    logic [7:0] s [13];
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
          8'h33, 8'h81, 8'h10, 8'h00, 8'h00};
    s[12] = csum;
    for (int i = 0; i < 13; i++) begin
      send_byte(s[i]);
      if (bubbles != 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic check_two_writes(input string name);
    tests_run++;
    if (wr_a.size() != 2) begin
      tests_failed++;
      $display("FAIL %s_write_count: got %0d required 2", name, wr_a.size());
    end else begin
      tests_run++;
      if (wr_a[0] !== 32'h0 || wr_d[0] !== 32'h0050_0093) begin
        tests_failed++;
        $display("FAIL %s_word0: got a=%h d=%h required a=00000000 d=00500093", name, wr_a[0], wr_d[0]);
      end
      tests_run++;
      if (wr_a[1] !== 32'h4 || wr_d[1] !== 32'h0010_8133) begin
        tests_failed++;
        $display("FAIL %s_word1: got a=%h d=%h required a=00000004 d=00108133", name, wr_a[1], wr_d[1]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({imem_we, imem_a, imem_wd, cpu_hold, done, error, loaded_words} !==
        {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got we=%b a=%h wd=%h hold=%b done=%b err=%b lw=%0d required 0/0/0/1/0/0/0",
               imem_we, imem_a, imem_wd, cpu_hold, done, error, loaded_words);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic test_basic_load();
    do_reset();
    send_image(8'hA7, 0);
    tests_run++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_status: got done=%b hold=%b err=%b required 1/0/0", done, cpu_hold, error);
    end
    tests_run++;
    if (loaded_words !== 32'd2) begin
      tests_failed++;
      $display("FAIL basic_loaded_words: got %0d required 2", loaded_words);
    end
    idle(3);
    check_two_writes("basic");
  endtask

  task automatic test_empty_image();
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_done_early: got %b required 0", done);
    end
    send_byte(8'h00);
    tests_run++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_done: got done=%b hold=%b required 1/0", done, cpu_hold);
    end
    idle(2);
    tests_run++;
    if (wr_a.size() != 0) begin
      tests_failed++;
      $display("FAIL empty_no_write: got %0d writes required 0", wr_a.size());
    end

    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01);
    tests_run++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_bad_csum: got err=%b hold=%b done=%b required 1/1/0", error, cpu_hold, done);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send_image(8'hA6, 0);
    idle(2);
    check_two_writes("badcsum");
    tests_run++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL badcsum_status: got err=%b done=%b hold=%b rdy=%b required 1/0/1/0",
               error, done, cpu_hold, in_ready);
    end
  endtask

  task automatic test_oversize_header();
    do_reset();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    tests_run++;
    if (error !== 1'b0) begin
      tests_failed++;
      $display("FAIL oversize_early: got err=%b required 0", error);
    end
    send_byte(8'h00);
    tests_run++;
    if (error !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      tests_failed++;
      $display("FAIL oversize_err: got err=%b rdy=%b hold=%b required 1/0/1", error, in_ready, cpu_hold);
    end
    idle(3);
    tests_run++;
    if (wr_a.size() != 0) begin
      tests_failed++;
      $display("FAIL oversize_no_write: got %0d writes required 0", wr_a.size());
    end
  endtask

  task automatic test_bubbles_and_junk();
    int accepted;
    do_reset();
    send_image(8'hA7, 1);
    check_two_writes("bubble");
    tests_run++;
    if (done !== 1'b1 || loaded_words !== 32'd2) begin
      tests_failed++;
      $display("FAIL bubble_status: got done=%b lw=%0d required 1/2", done, loaded_words);
    end
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF - 8'(i);
      if (in_ready !== 1'b0) accepted++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (accepted != 0 || wr_a.size() != 2 || done !== 1'b1 || loaded_words !== 32'd2) begin
      tests_failed++;
      $display("FAIL junk_after_done: got ready_cycles=%0d writes=%0d done=%b lw=%0d required 0/2/1/2",
               accepted, wr_a.size(), done, loaded_words);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h81);
    tests_run++;
    if (wr_a.size() != 1 || loaded_words !== 32'd1) begin
      tests_failed++;
      $display("FAIL midreset_pre: got writes=%0d lw=%0d required 1/1", wr_a.size(), loaded_words);
    end
    do_reset();
    tests_run++;
    if (loaded_words !== 32'd0 || imem_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_cleared: got lw=%0d a=%h required 0/00000000", loaded_words, imem_a);
    end
    send_image(8'hA7, 0);
    idle(2);
    check_two_writes("midreset");
    tests_run++;
    if (loaded_words !== 32'd2 || done !== 1'b1 || cpu_hold !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_final: got lw=%0d done=%b hold=%b required 2/1/0", loaded_words, done, cpu_hold);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_basic_load();
    test_empty_image();
    test_bad_checksum();
    test_oversize_header();
    test_bubbles_and_junk();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer end of the instruction memory interface. The CPU only ever reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into instruction memory.
- Holds the CPU (cpu_hold) until the image has loaded and its checksum has verified.
- Sits between the bench/host byte source and the instruction_memory write port.

Parameters:
ADDR_BASE, 0, byte address of the first loaded word; word k is written at ADDR_BASE + 4*k
MAX_WORDS, 512, largest accepted word count; a larger header value is an error

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  source has a byte on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_a  output  32  instruction memory byte address
imem_wd  output  32  instruction memory write data
cpu_hold  output  1  1 = CPU must stay stalled / PC held
done  output  1  image loaded and checksum matched
error  output  1  bad header or checksum mismatch
loaded_words  output  32  count of words written since reset

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high.
  - While reset = 1 at a rising edge: state = HDR, all counters = 0, imem_we = 0, imem_a = ADDR_BASE, imem_wd = 0, cpu_hold = 1, done = 0, error = 0, loaded_words = 0.
  - in_ready = 0 whenever reset = 1.
- Byte transfer:
  - A byte transfers on a rising edge with in_valid = 1 and in_ready = 1.
  - in_ready = 1 exactly in states HDR, LOAD and CSUM.
  - in_data is ignored when no transfer occurs. Bubbles (in_valid = 0) are allowed anywhere.
- Stream format:
  - 4-byte word count N, little-endian.
  - Then N words, 4 bytes each, little-endian.
  - Then 1 checksum byte = (sum of all 4N payload bytes) mod 256. Header bytes are not summed.
- HDR state:
  - Collect 4 bytes into N.
  - On the 4th byte: N > MAX_WORDS -> ERR; N = 0 -> CSUM; else -> LOAD.
- LOAD state:
  - Shift bytes into a word assembly register; keep an 8-bit running sum of every payload byte.
  - On the 4th byte of word k: the next cycle presents imem_we = 1 for exactly one cycle, imem_a = ADDR_BASE + 4*k, imem_wd = assembled word.
  - loaded_words increments in that same cycle.
  - After the Nth word's 4th byte -> CSUM.
  - in_ready stays 1 during the write pulse; the next word cannot complete in under 4 cycles, so writes never overlap.
- CSUM state:
  - Accept 1 byte. Equal to the running sum -> DONE; otherwise -> ERR.
  - If the last word's write pulse is still pending when the checksum byte arrives, the write still completes.
- DONE state: in_ready = 0, done = 1, cpu_hold = 0. Terminal until reset.
- ERR state: in_ready = 0, error = 1, cpu_hold = 1. Terminal until reset.
- Output timing and address arithmetic:
  - done, error and cpu_hold change in the cycle after the deciding byte is accepted.
  - imem_a retains its last value between pulses.
  - Address arithmetic is 32-bit, wraps modulo 2^32 with no check.
- Reset mid-operation: aborts immediately and returns to HDR with all counters cleared. Words already written stay in memory. A pending write pulse is cancelled if reset is high on that edge.
- Never: imem_we asserted in HDR, CSUM-only images, DONE or ERR other than the final pending word; done and error both 1.

Test Plan:
- Stream 02 00 00 00, 93 00 50 00, 33 81 10 00, A7 -> 0x00500093 written at 0, 0x00108133 at 4, each a 1-cycle imem_we pulse. Then done = 1, cpu_hold = 0, loaded_words = 2. After 20 more CPU cycles, register x2 = 10.
- Stream 00 00 00 00, 00 -> no imem_we, done = 1 one cycle after the checksum byte. Same with checksum 01 -> error = 1, cpu_hold = 1.
- Two-word image as above, checksum A6 -> both words written, error = 1, done = 0, cpu_hold = 1, in_ready = 0.
- Header 01 02 00 00 (N = 513, MAX_WORDS = 512) -> ERR one cycle after the 4th byte, no imem_we, in_ready = 0.
- Two-word image with in_valid toggled randomly (≥3 bubbles per word) -> identical writes and addresses as the first scenario. Also inject in_valid = 1 with junk bytes after DONE -> no transfers, no writes.
- Reset pulsed after 6 payload bytes, then the full first-scenario stream -> first word not rewritten early. Final memory and outputs match the first scenario; loaded_words = 2 (not 3).
